instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Upstream neighbour of the main decoder: holds the PC, reads the instruction ROM, presents opcode to decoder.
//  Computes next PC from sequential/branch(/jump) each cycle; a small run/halt FSM gates the stream.
//  Emits a zero opcode (decodes to no-op) whenever no valid instruction is present.
// PARAMETERS
//  DEPTH        256         instruction ROM depth in 32-bit words (power of two)
//  RESET_PC     32'h0       PC value loaded on reset (word aligned)
//  INIT_FILE    "imem.hex"  $readmemh image for the ROM
//  HALT_OPCODE  8'hFF       opcode that stops fetch
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  stall      in   1   hold PC and outputs this cycle
//  branch     in   1   branch request from decoder
//  zero       in   1   ALU zero flag
//  pc         out  32  current PC
//  pc_plus4   out  32  pc + 4
//  instr      out  32  current instruction word (raw ROM data)
//  opcode     out  8   instr[31:24] when valid, else 8'h00
//  valid      out  1   instr is a real, executing instruction
//  halted     out  1   FSM in HALT
//  addr_err   out  1   sticky: halted because PC left ROM range
//  icount     out  32  retired-instruction counter
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset: pc=RESET_PC, state=BOOT, valid=0, halted=0, addr_err=0, icount=0, opcode=0. Reset mid-run always wins.
//  ROM read is combinational: instr = rom[pc[log2(DEPTH)+1:2]]; pc[1:0] ignored.
//  FSM BOOT->RUN unconditionally after one cycle (one bubble, valid=0).
//  RUN, stall=0: pc<=next_pc, icount<=icount+1 (wraps mod 2^32). stall=1: pc/icount hold, valid stays 1.
//  next_pc priority: jump (macro) > branch&zero -> pc_plus4 + (sext(instr[15:0])<<2) > pc_plus4. All 32-bit, wrap mod 2^32.
//  RUN, opcode==HALT_OPCODE: valid=0, opcode=0 same cycle; next state HALT, pc frozen on halt word, icount not incremented.
//  RUN, pc[31:2] >= DEPTH: treated as halt; additionally addr_err<=1.
//  Halt check takes priority over stall.
//  HALT: valid=0, halted=1, opcode=0, stall/branch ignored; only reset leaves.
//  Branch target out of range -> addr_err on next cycle, never an X read.
// CONFIGURATION
//  Macro FETCH_JUMP_EN:
//   defined: opcode[2:0]==3'b100 (valid) is a jump; next_pc = {pc_plus4[31:26], instr[23:0], 2'b00}.
//   undefined: that opcode advances sequentially (pc_plus4); no jump logic synthesised.
// STRUCTURE
//  Shared header fetch_defs.vh: FSM state codes (BOOT=2'd0, RUN=2'd1, HALT=2'd2), OPC_JUMP=3'b100,
//   HALT_OPCODE default, INSTR_W=32, OPC_W=8.
//  One sub-module: next_pc_logic (combinational: pc, instr, branch, zero -> next_pc, pc_plus4).
//  Top holds PC reg, FSM, icount, addr_err, ROM array.
// TESTING
//  Reset then 3 clk, ROM={add,lw,sw}: cycle0 valid=0 opc=0; pc 0->4->8; icount=2.
//  beq at pc=8, offset=16'h0003, branch=1 zero=1 -> pc=24; zero=0 -> pc=12.
//  Negative offset 16'hFFFE at pc=16, taken -> pc=12.
//  stall=1 for 2 cycles in RUN -> pc/icount unchanged, valid=1, then resumes.
//  HALT_OPCODE at pc=12 -> same cycle opc=0 valid=0; next halted=1, pc=12 forever; reset -> BOOT, pc=0.
//  FETCH_JUMP_EN, jump instr[23:0]=24'h000010 -> pc=0x40; undefined -> pc+4. Jump past DEPTH -> addr_err=1, halted=1.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: FSM state codes, opcode constants, bus widths, branch displacement helper.
// No logic of its own; no latency.
// No flow control; consumed by the fetch top and its next-PC sub-block.
package instr_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 8;

    localparam logic [OPC_W-1:0] HALT_OPCODE_DEF = 8'hFF;
    localparam logic [2:0]       OPC_JUMP        = 3'b100;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Branch displacement: signed 16-bit word offset scaled to bytes.
    function automatic logic [INSTR_W-1:0] branch_disp(input logic [INSTR_W-1:0] instr);
        return {{14{instr[15]}}, instr[15:0], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_next_pc_logic.sv
// Next-PC selection: jump (FETCH_JUMP_EN) > taken branch > sequential; all arithmetic wraps mod 2^32.
// Purely combinational, zero latency.
// No flow control; the caller decides whether next_pc is loaded.
module next_pc_logic
    import instr_fetch_pkg::*;
(
    input  logic [INSTR_W-1:0] pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic               zero,
    output logic [INSTR_W-1:0] next_pc,
    output logic [INSTR_W-1:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        if (branch && zero) begin
            next_pc = pc_plus4 + branch_disp(instr);
        end
`ifdef FETCH_JUMP_EN
        // Jump keeps the top six bits of the sequential PC (region-relative target).
        if (instr[26:24] == OPC_JUMP) begin
            next_pc = {pc_plus4[31:26], instr[23:0], 2'b00};
        end
`endif
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, combinational ROM read, BOOT/RUN/HALT gating, retire counter; FETCH_JUMP_EN adds jumps.
// Zero-latency ROM read: instr/opcode follow pc in the same cycle; one bubble after reset.
// stall holds pc/icount with valid kept high; halt (opcode or PC out of ROM) overrides stall.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                 DEPTH       = 256,
    parameter logic [INSTR_W-1:0] RESET_PC    = 32'h0,
    parameter string              INIT_FILE   = "imem.hex",
    parameter logic [OPC_W-1:0]   HALT_OPCODE = HALT_OPCODE_DEF,
    parameter logic [INSTR_W-1:0] ROM_IMAGE [DEPTH] = '{default: 32'h0}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch,
    input  logic               zero,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus4,
    output logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic               valid,
    output logic               halted,
    output logic               addr_err,
    output logic [INSTR_W-1:0] icount
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q;
    logic [INSTR_W-1:0] icount_q;
    logic               addr_err_q;
    logic [INSTR_W-1:0] next_pc;
    logic [AW-1:0]      rom_idx;
    logic               in_range;
    logic               halt_req;
    logic               advance;

    // Index is always a legal ROM word; out-of-range PCs are masked by in_range instead.
    assign rom_idx  = pc_q[AW+1:2];
    assign instr    = ROM_IMAGE[rom_idx];
    assign in_range = (pc_q[INSTR_W-1:AW+2] == '0);

    next_pc_logic u_next_pc (
        .pc       (pc_q),
        .instr    (instr),
        .branch   (branch),
        .zero     (zero),
        .next_pc  (next_pc),
        .pc_plus4 (pc_plus4)
    );

    always_comb begin
        state_d  = state_q;
        halt_req = 1'b0;
        advance  = 1'b0;
        valid    = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!in_range || instr[31:24] == HALT_OPCODE) begin
                    halt_req = 1'b1;
                    state_d  = HALT;
                end else begin
                    valid   = 1'b1;
                    advance = !stall;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            icount_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                pc_q     <= next_pc;
                icount_q <= icount_q + 32'd1;
            end
            if (halt_req && !in_range) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign pc       = pc_q;
    assign icount   = icount_q;
    assign addr_err = addr_err_q;
    assign halted   = (state_q == HALT);
    assign opcode   = valid ? instr[31:24] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: boot bubble, sequential fetch, branches, stall, halt, address error, jump.
module tb_instr_fetch;

    localparam int TB_DEPTH = 32;

    // add, lw(off 2), beq(+3), HALT, beq(-2), jump(0x10), add(off 0x40), ..., sw @0x40, jump(0x40) @0x44
    localparam logic [31:0] IMG [TB_DEPTH] = '{
        32'h01000000, 32'h02000002, 32'h05000003, 32'hFF000000,
        32'h0500FFFE, 32'h0C000010, 32'h01000040, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h03000000, 32'h0C000040, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] pc, pc_plus4, instr, icount;
    logic [7:0]  opcode;
    logic        valid, halted, addr_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .DEPTH     (TB_DEPTH),
        .ROM_IMAGE (IMG)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .branch   (branch),
        .zero     (zero),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .opcode   (opcode),
        .valid    (valid),
        .halted   (halted),
        .addr_err (addr_err),
        .icount   (icount)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in BOOT with pc at the reset value.
    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; branch = 1'b0; zero = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pc !== 32'h0)     begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        total++; if (valid !== 1'b0)   begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (opcode !== 8'h00) begin bad++; $display("FAIL reset_opcode: got %h want 00", opcode); end
        total++; if (halted !== 1'b0)  begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
        total++; if (icount !== 32'h0) begin bad++; $display("FAIL reset_icount: got %h want 0", icount); end
    endtask

    task automatic test_sequential();
        step();
        total++; if (valid !== 1'b1 || pc !== 32'h0 || opcode !== 8'h01)
            begin bad++; $display("FAIL seq_first: valid=%b pc=%h opc=%h want 1/0/01", valid, pc, opcode); end
        step();
        total++; if (pc !== 32'h4 || opcode !== 8'h02)
            begin bad++; $display("FAIL seq_second: pc=%h opc=%h want 4/02", pc, opcode); end
        step();
        total++; if (pc !== 32'h8 || icount !== 32'd2)
            begin bad++; $display("FAIL seq_third: pc=%h icount=%0d want 8/2", pc, icount); end
        total++; if (pc_plus4 !== 32'hC || instr !== 32'h05000003)
            begin bad++; $display("FAIL seq_rom: pc_plus4=%h instr=%h want c/05000003", pc_plus4, instr); end
    endtask

    task automatic test_branch_taken();
        do_reset();
        step(); step(); step();
        branch = 1'b1; zero = 1'b1;
        step();
        branch = 1'b0; zero = 1'b0;
        total++; if (pc !== 32'd24 || icount !== 32'd3 || opcode !== 8'h01)
            begin bad++; $display("FAIL br_taken: pc=%h icount=%0d opc=%h want 18/3/01", pc, icount, opcode); end
    endtask

    // Continues from pc=24: displacement 0x40 words lands beyond the 32-word ROM.
    task automatic test_addr_range();
        branch = 1'b1; zero = 1'b1;
        step();
        branch = 1'b0; zero = 1'b0;
        total++; if (pc !== 32'h11C || valid !== 1'b0 || opcode !== 8'h00 || addr_err !== 1'b0 || halted !== 1'b0)
            begin bad++; $display("FAIL oor_entry: pc=%h v=%b opc=%h ae=%b h=%b want 11c/0/00/0/0", pc, valid, opcode, addr_err, halted); end
        step();
        total++; if (halted !== 1'b1 || addr_err !== 1'b1 || pc !== 32'h11C || icount !== 32'd4)
            begin bad++; $display("FAIL oor_halt: h=%b ae=%b pc=%h icount=%0d want 1/1/11c/4", halted, addr_err, pc, icount); end
        step();
        total++; if (addr_err !== 1'b1)
            begin bad++; $display("FAIL oor_sticky: ae=%b want 1", addr_err); end
    endtask

    task automatic test_not_taken_halt();
        do_reset();
        step(); step(); step();
        branch = 1'b1; zero = 1'b0;
        step();
        total++; if (pc !== 32'd12)
            begin bad++; $display("FAIL br_not_taken: pc=%h want c", pc); end
        total++; if (valid !== 1'b0 || opcode !== 8'h00 || halted !== 1'b0 || instr !== 32'hFF000000)
            begin bad++; $display("FAIL halt_same_cycle: v=%b opc=%h h=%b instr=%h want 0/00/0/ff000000", valid, opcode, halted, instr); end
        stall = 1'b1; branch = 1'b1; zero = 1'b1;
        step();
        total++; if (halted !== 1'b1 || pc !== 32'd12 || icount !== 32'd3 || addr_err !== 1'b0)
            begin bad++; $display("FAIL halt_enter: h=%b pc=%h icount=%0d ae=%b want 1/c/3/0", halted, pc, icount, addr_err); end
        stall = 1'b0;
        step(); step(); step();
        total++; if (halted !== 1'b1 || pc !== 32'd12 || valid !== 1'b0)
            begin bad++; $display("FAIL halt_frozen: h=%b pc=%h v=%b want 1/c/0", halted, pc, valid); end
        do_reset();
        total++; if (halted !== 1'b0 || pc !== 32'h0 || valid !== 1'b0 || icount !== 32'h0)
            begin bad++; $display("FAIL halt_reset: h=%b pc=%h v=%b icount=%0d want 0/0/0/0", halted, pc, valid, icount); end
    endtask

    task automatic test_neg_branch();
        do_reset();
        step(); step();
        branch = 1'b1; zero = 1'b1;
        step();
        total++; if (pc !== 32'd16)
            begin bad++; $display("FAIL br_fwd2: pc=%h want 10", pc); end
        step();
        branch = 1'b0; zero = 1'b0;
        total++; if (pc !== 32'd12 || icount !== 32'd3)
            begin bad++; $display("FAIL br_neg: pc=%h icount=%0d want c/3", pc, icount); end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step();
        stall = 1'b1;
        step(); step();
        total++; if (pc !== 32'h4 || icount !== 32'd1 || valid !== 1'b1 || opcode !== 8'h02)
            begin bad++; $display("FAIL stall_hold: pc=%h icount=%0d v=%b opc=%h want 4/1/1/02", pc, icount, valid, opcode); end
        stall = 1'b0;
        step();
        total++; if (pc !== 32'h8 || icount !== 32'd2)
            begin bad++; $display("FAIL stall_resume: pc=%h icount=%0d want 8/2", pc, icount); end
    endtask

    task automatic test_jump();
        do_reset();
        step(); step();
        branch = 1'b1; zero = 1'b1;
        step();
        branch = 1'b0; zero = 1'b0;
        step();
        total++; if (pc !== 32'd20 || opcode !== 8'h0C || valid !== 1'b1)
            begin bad++; $display("FAIL jump_fetch: pc=%h opc=%h v=%b want 14/0c/1", pc, opcode, valid); end
        step();
`ifdef FETCH_JUMP_EN
        total++; if (pc !== 32'h40 || opcode !== 8'h03)
            begin bad++; $display("FAIL jump_target: pc=%h opc=%h want 40/03", pc, opcode); end
        step(); step();
        total++; if (pc !== 32'h100 || valid !== 1'b0)
            begin bad++; $display("FAIL jump_oor: pc=%h v=%b want 100/0", pc, valid); end
        step();
        total++; if (halted !== 1'b1 || addr_err !== 1'b1 || pc !== 32'h100)
            begin bad++; $display("FAIL jump_oor_halt: h=%b ae=%b pc=%h want 1/1/100", halted, addr_err, pc); end
`else
        total++; if (pc !== 32'd24 || icount !== 32'd4 || opcode !== 8'h01)
            begin bad++; $display("FAIL jump_disabled: pc=%h icount=%0d opc=%h want 18/4/01", pc, icount, opcode); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_taken();
        test_addr_range();
        test_not_taken_halt();
        test_neg_branch();
        test_stall();
        test_jump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

endmodule
